// File: rtl/noc_router_pkg.sv
// -----------------------------------------------------------------------------
// noc_router_pkg
// Shared definitions for the parametrised mesh router:
//   - port index constants (N=0, S=1, E=2, W=3, L=4) and the port count
//   - port_e enum naming the five router ports
//   - route(): dimension-ordered XY routing decision for one flit header
// -----------------------------------------------------------------------------
package noc_router_pkg;

    localparam int N      = 0;
    localparam int S      = 1;
    localparam int E      = 2;
    localparam int W      = 3;
    localparam int L      = 4;
    localparam int NPORTS = 5;

    // Coordinates are zero-extended to this width before comparison, so any
    // COORD_W up to this value can share the one routing function.
    localparam int COORD_MAX_W = 16;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // X first, then Y, then local delivery. All comparisons unsigned.
    function automatic port_e route(
        input logic [COORD_MAX_W-1:0] dest_x,
        input logic [COORD_MAX_W-1:0] dest_y,
        input logic [COORD_MAX_W-1:0] here_x,
        input logic [COORD_MAX_W-1:0] here_y
    );
        port_e sel;
        if (dest_x > here_x) begin
            sel = PORT_E;
        end else if (dest_x < here_x) begin
            sel = PORT_W;
        end else if (dest_y > here_y) begin
            sel = PORT_N;
        end else if (dest_y < here_y) begin
            sel = PORT_S;
        end else begin
            sel = PORT_L;
        end
        return sel;
    endfunction

endpackage

// File: rtl/router_in_fifo.sv
// -----------------------------------------------------------------------------
// router_in_fifo
// Per-input flit buffer of the mesh router. First-word-fall-through: a flit
// written in cycle t is presented at the head in cycle t+1.
// Ports:
//   clk, rst      clock, synchronous active-low reset (empties the buffer)
//   wr_en/wr_data write strobe and flit
//   rd_en         pop the head (ignored when empty)
//   head_data     flit at the head of the buffer
//   head_valid    buffer not empty
//   full          all BUF_DEPTH slots occupied
//   ovf           pulse: write arrived while full and no pop made room
// -----------------------------------------------------------------------------
module router_in_fifo #(
    parameter int DATA_W    = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic              full,
    output logic              ovf
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic              empty;
    logic              push;
    logic              pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write to a full buffer
    // is still accepted when the head leaves.
    assign push = wr_en && (!full || pop);
    assign ovf  = wr_en && full && !pop;

    assign head_valid = !empty;
    // Asynchronous head read keeps the one-cycle write-to-head latency.
    assign head_data  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mesh_router_param.sv
// -----------------------------------------------------------------------------
// mesh_router_param
// Five-port (N/S/E/W/L) mesh router for single-flit packets with XY routing.
// PORT_EN removes absent ports so one module covers edge and corner routers.
// Each input has a FIFO with credit return; each output has a round-robin
// arbiter, a credit counter towards the downstream buffer and a registered
// output stage.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   in_data_i     flit per input port, port i at [i*DATA_W +: DATA_W]
//   in_valid_i    write strobe per input port
//   in_credit_o   pulse per input: one input FIFO slot freed
//   out_data_o    flit per output port
//   out_valid_o   flit valid per output port
//   out_credit_i  credit-return pulse per output from downstream
//   drop_o        pulse: a flit routed to a disabled port was discarded
//   ovf_o         sticky: a write hit a full input FIFO
// -----------------------------------------------------------------------------
module mesh_router_param
    import noc_router_pkg::*;
#(
    parameter int                XCOORD    = 0,
    parameter int                YCOORD    = 0,
    parameter int                DATA_W    = 16,
    parameter int                COORD_W   = 4,
    parameter int                BUF_DEPTH = 4,
    parameter logic [NPORTS-1:0] PORT_EN   = 5'b11111
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS*DATA_W-1:0] in_data_i,
    input  logic [NPORTS-1:0]        in_valid_i,
    output logic [NPORTS-1:0]        in_credit_o,
    output logic [NPORTS*DATA_W-1:0] out_data_o,
    output logic [NPORTS-1:0]        out_valid_o,
    input  logic [NPORTS-1:0]        out_credit_i,
    output logic                     drop_o,
    output logic                     ovf_o
);

    localparam logic [COORD_W-1:0] HERE_X = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(YCOORD);
    localparam int                 CW     = $clog2(BUF_DEPTH) + 1;

    logic [DATA_W-1:0] head_data [NPORTS];
    logic [2:0]        route_sel [NPORTS];
    logic [2:0]        grant_idx [NPORTS];
    logic [NPORTS-1:0] head_valid;
    logic [NPORTS-1:0] fifo_full;
    logic [NPORTS-1:0] ovf_pulse;
    logic [NPORTS-1:0] drop_req;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] grant_vld;
    logic              drop_reg;
    logic              ovf_reg;

    // ------------------------------------------------------------------
    // Input side: buffer, route computation, pop and credit return
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < NPORTS; gi++) begin : g_in
        logic credit_ret_reg;
        logic granted;

        router_in_fifo #(
            .DATA_W    (DATA_W),
            .BUF_DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (in_valid_i[gi] & PORT_EN[gi]),
            .wr_data    (in_data_i[gi*DATA_W +: DATA_W]),
            .rd_en      (pop[gi]),
            .head_data  (head_data[gi]),
            .head_valid (head_valid[gi]),
            .full       (fifo_full[gi]),
            .ovf        (ovf_pulse[gi])
        );

        assign route_sel[gi] = route(
            COORD_MAX_W'(head_data[gi][2*COORD_W-1:COORD_W]),
            COORD_MAX_W'(head_data[gi][COORD_W-1:0]),
            COORD_MAX_W'(HERE_X),
            COORD_MAX_W'(HERE_Y)
        );

        // A head aimed at an absent port would block this input forever;
        // it is discarded instead, without touching any output credit.
        assign drop_req[gi] = head_valid[gi] & ~PORT_EN[route_sel[gi]];

        // Each head requests exactly one output, so at most one grant hits.
        always_comb begin
            granted = 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                if (grant_vld[o] && (grant_idx[o] == 3'(gi))) begin
                    granted = 1'b1;
                end
            end
        end

        assign pop[gi] = granted | drop_req[gi];

        always_ff @(posedge clk) begin
            if (!rst) begin
                credit_ret_reg <= 1'b0;
            end else begin
                credit_ret_reg <= pop[gi] & PORT_EN[gi];
            end
        end

        assign in_credit_o[gi] = credit_ret_reg;
    end

    // ------------------------------------------------------------------
    // Output side: round-robin arbiter, credit counter, output register
    // ------------------------------------------------------------------
    for (gi = 0; gi < NPORTS; gi++) begin : g_out
        logic [NPORTS-1:0] req;
        logic              gv;
        logic [2:0]        gidx;
        logic [3:0]        sum;
        logic [CW-1:0]     credit_reg;
        logic [2:0]        ptr_reg;
        logic              valid_reg;
        logic [DATA_W-1:0] data_reg;

        always_comb begin
            req = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req[i] = head_valid[i] && (route_sel[i] == 3'(gi));
            end
        end

        // Scan from the highest offset down so the last hit written is the
        // first requester at or above the pointer (wrapping 4 -> 0).
        always_comb begin
            gv   = 1'b0;
            gidx = '0;
            sum  = '0;
            if (PORT_EN[gi] && (credit_reg != '0)) begin
                for (int k = NPORTS - 1; k >= 0; k--) begin
                    sum = {1'b0, ptr_reg} + 4'(k);
                    if (sum >= 4'(NPORTS)) begin
                        sum = sum - 4'(NPORTS);
                    end
                    if (req[sum[2:0]]) begin
                        gv   = 1'b1;
                        gidx = sum[2:0];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                credit_reg <= CW'(BUF_DEPTH);
                ptr_reg    <= '0;
                valid_reg  <= 1'b0;
                data_reg   <= '0;
            end else begin
                valid_reg <= gv;
                if (gv) begin
                    data_reg <= head_data[gidx];
                    ptr_reg  <= (gidx == 3'(NPORTS - 1)) ? 3'd0 : gidx + 3'd1;
                end
                // Returned credit and a grant in the same cycle cancel out;
                // credits beyond the downstream depth are ignored.
                case ({out_credit_i[gi], gv})
                    2'b10: begin
                        if (credit_reg != CW'(BUF_DEPTH)) begin
                            credit_reg <= credit_reg + CW'(1);
                        end
                    end
                    2'b01:   credit_reg <= credit_reg - CW'(1);
                    default: credit_reg <= credit_reg;
                endcase
            end
        end

        assign grant_vld[gi] = gv;
        assign grant_idx[gi] = gidx;

        assign out_valid_o[gi]                  = valid_reg;
        assign out_data_o[gi*DATA_W +: DATA_W]  = PORT_EN[gi] ? data_reg : '0;
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            drop_reg <= |drop_req;
            // A rejected write can only happen against a full buffer.
            ovf_reg  <= ovf_reg | (|(ovf_pulse & fifo_full));
        end
    end

    assign drop_o = drop_reg;
    assign ovf_o  = ovf_reg;

endmodule

// File: tb/tb_mesh_router_param.sv
// -----------------------------------------------------------------------------
// tb_mesh_router_param
// Directed bench for mesh_router_param at router (1,1). A fully populated
// router (dut) and an east-edge router (dut_e, PORT_EN=5'b11011) receive the
// same stimulus; each scenario starts from reset.
// -----------------------------------------------------------------------------
module tb_mesh_router_param;
    import noc_router_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [5*DW-1:0] in_data;
    logic [4:0]    in_valid;
    logic [4:0]    out_credit;

    logic [4:0]    in_credit,   e_in_credit;
    logic [5*DW-1:0] out_data,  e_out_data;
    logic [4:0]    out_valid,   e_out_valid;
    logic          drop,        e_drop;
    logic          ovf,         e_ovf;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mesh_router_param #(
        .XCOORD(1), .YCOORD(1), .DATA_W(DW), .COORD_W(4), .BUF_DEPTH(4),
        .PORT_EN(5'b11111)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_credit_o(in_credit),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_credit_i(out_credit),
        .drop_o(drop), .ovf_o(ovf)
    );

    mesh_router_param #(
        .XCOORD(1), .YCOORD(1), .DATA_W(DW), .COORD_W(4), .BUF_DEPTH(4),
        .PORT_EN(5'b11011)
    ) dut_e (
        .clk(clk), .rst(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_credit_o(e_in_credit),
        .out_data_o(e_out_data), .out_valid_o(e_out_valid), .out_credit_i(out_credit),
        .drop_o(e_drop), .ovf_o(e_ovf)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("vec %0d %s ok value=%0h", vectors, tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [DW-1:0] flit);
        in_data[p*DW +: DW] = flit;
        in_valid[p]         = 1'b1;
    endtask

    task automatic clear();
        in_valid   = '0;
        in_data    = '0;
        out_credit = '0;
    endtask

    task automatic do_reset();
        clear();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [DW-1:0] oslice(input logic [5*DW-1:0] v, input int p);
        return v[p*DW +: DW];
    endfunction

    int delivered;

    initial begin
        rst = 1'b0;
        clear();
        tick();
        tick();
        // Reset state
        chk("rst_out_valid", 80'(out_valid), 80'h0);
        chk("rst_out_data", 80'(out_data), 80'h0);
        chk("rst_in_credit", 80'(in_credit), 80'h0);
        chk("rst_drop", 80'(drop), 80'h0);
        chk("rst_ovf", 80'(ovf), 80'h0);
        rst = 1'b1;
        tick();

        // Zero-load path L -> E, dest (2,1)
        put(L, 16'h0021);
        tick();
        clear();
        chk("t1_valid_early", 80'(out_valid), 80'h0);
        tick();
        chk("t1_valid", 80'(out_valid), 80'b00100);
        chk("t1_data", 80'(oslice(out_data, E)), 80'h0021);
        chk("t1_credit", 80'(in_credit), 80'b10000);
        tick();
        chk("t1_valid_after", 80'(out_valid), 80'h0);
        chk("t1_credit_after", 80'(in_credit), 80'h0);

        // Round robin on L: N, S, W contend with pointer 0
        do_reset();
        put(N, 16'hA011);
        put(S, 16'hB011);
        put(W, 16'hC011);
        tick();
        clear();
        tick();
        chk("t2_first_valid", 80'(out_valid), 80'b10000);
        chk("t2_first_data", 80'(oslice(out_data, L)), 80'hA011);
        chk("t2_first_credit", 80'(in_credit), 80'b00001);
        tick();
        chk("t2_second_data", 80'(oslice(out_data, L)), 80'hB011);
        chk("t2_second_credit", 80'(in_credit), 80'b00010);
        tick();
        chk("t2_third_data", 80'(oslice(out_data, L)), 80'hC011);
        chk("t2_third_credit", 80'(in_credit), 80'b01000);
        out_credit[L] = 1'b1;   // L had one credit left; restore a second
        tick();
        clear();
        chk("t2_idle_valid", 80'(out_valid), 80'h0);
        put(L, 16'hD011);
        put(N, 16'hE011);
        tick();
        clear();
        tick();
        chk("t2_ptr4_first", 80'(oslice(out_data, L)), 80'hD011);
        tick();
        chk("t2_ptr4_second", 80'(oslice(out_data, L)), 80'hE011);
        chk("t2_ptr4_second_valid", 80'(out_valid), 80'b10000);
        tick();
        chk("t2_idle_end", 80'(out_valid), 80'h0);

        // Credit exhaustion on E: 5 flits, 4 delivered, 5th after one credit
        do_reset();
        for (int k = 0; k < 5; k++) begin
            put(L, {4'(k + 1), 12'h021});
            tick();
            if (k >= 1) begin
                chk($sformatf("t3_flit%0d", k - 1), 80'({out_valid[E], oslice(out_data, E)}),
                    80'({1'b1, 4'(k), 12'h021}));
            end
        end
        clear();
        tick();
        chk("t3_stall_a", 80'(out_valid[E]), 80'h0);
        tick();
        chk("t3_stall_b", 80'(out_valid[E]), 80'h0);
        out_credit[E] = 1'b1;
        tick();
        clear();
        chk("t3_credit_edge", 80'(out_valid[E]), 80'h0);
        tick();
        chk("t3_fifth", 80'({out_valid[E], oslice(out_data, E)}), 80'({1'b1, 16'h5021}));
        chk("t3_fifth_credit", 80'(in_credit), 80'b10000);
        tick();
        chk("t3_done", 80'(out_valid[E]), 80'h0);

        // East-edge router: flit to absent E port is dropped
        do_reset();
        put(L, 16'h0031);
        tick();
        clear();
        chk("t4_drop_early", 80'(e_drop), 80'h0);
        tick();
        chk("t4_drop", 80'(e_drop), 80'h1);
        chk("t4_in_credit", 80'(e_in_credit), 80'b10000);
        chk("t4_out_valid", 80'(e_out_valid), 80'h0);
        chk("t4_e_data", 80'(oslice(e_out_data, E)), 80'h0);
        tick();
        chk("t4_drop_once", 80'(e_drop), 80'h0);
        chk("t4_credit_once", 80'(e_in_credit), 80'h0);
        chk("t4_out_valid_after", 80'(e_out_valid), 80'h0);

        // Overflow on N while S is out of credits, then reset recovery
        do_reset();
        for (int k = 0; k < 4; k++) begin
            put(N, 16'h0010);
            tick();
        end
        clear();
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 4; k++) begin
            put(N, {4'(k + 1), 12'h010});
            tick();
        end
        chk("t5_no_ovf_full", 80'(ovf), 80'h0);
        put(N, 16'hF010);
        tick();
        clear();
        chk("t5_ovf", 80'(ovf), 80'h1);
        tick();
        tick();
        chk("t5_ovf_sticky", 80'(ovf), 80'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5_ovf_reset", 80'(ovf), 80'h0);
        chk("t5_valid_reset", 80'(out_valid), 80'h0);
        chk("t5_credit_reset", 80'(in_credit), 80'h0);
        delivered = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            delivered += int'(out_valid[S]);
        end
        chk("t5_fifo_empty", 80'(delivered), 80'd0);
        delivered = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) put(N, 16'h0010);
            else clear();
            tick();
            delivered += int'(out_valid[S]);
        end
        clear();
        chk("t5_credits_4", 80'(delivered), 80'd4);

        // Grant and credit return on E in the same cycle with one credit left
        do_reset();
        for (int k = 0; k < 3; k++) begin
            put(L, {4'(k + 1), 12'h021});
            tick();
        end
        clear();
        for (int k = 0; k < 4; k++) tick();
        put(L, 16'h6021);
        tick();
        put(L, 16'h7021);
        out_credit[E] = 1'b1;
        tick();
        clear();
        chk("t6_first", 80'({out_valid[E], oslice(out_data, E)}), 80'({1'b1, 16'h6021}));
        tick();
        chk("t6_no_stall", 80'({out_valid[E], oslice(out_data, E)}), 80'({1'b1, 16'h7021}));
        tick();
        chk("t6_idle", 80'(out_valid[E]), 80'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
